// File: rtl/mem_access_arbiter_pkg.sv
// rtl/mem_access_arbiter_pkg.sv - shared encodings for the memory access arbiter
//
// Purpose: address-mux select codes, FSM state encoding, bus owner enum and
// the tie-break helper used by the arbiter.
// Ports: none (package).

package mem_access_arbiter_pkg;

  localparam logic [1:0] SEL_PC   = 2'b00;
  localparam logic [1:0] SEL_DATA = 2'b01;
  localparam logic [1:0] SEL_INC  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // On a tie the requester that did not win last time gets the bus.
  function automatic owner_t pick_owner(input logic   fetch_req,
                                        input logic   data_req,
                                        input owner_t last_grant);
    if (fetch_req && data_req) begin
      return (last_grant == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    end else if (fetch_req) begin
      return OWN_FETCH;
    end else begin
      return OWN_DATA;
    end
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - per-beat wait counter with timeout detection
//
// Purpose: counts ACCESS cycles that end without mem_ready.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the count (asserted the cycle before ACCESS is entered)
//   enable    - one more cycle spent waiting
//   expired   - this waiting cycle brings the count to MAX_WAIT

module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  // Combinational so the FSM leaves ACCESS at the end of the MAX_WAIT-th cycle.
  assign expired = enable && (count == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CW'(MAX_WAIT))) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - fetch/data memory access arbiter and sequencer
//
// Purpose: arbitrates instruction-fetch and data requests onto one memory
// port, sequences address load and access beats, and times out stalled beats.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   fetch_req, data_req        - requests, held until their ack
//   data_we                    - data direction, captured at grant
//   mem_ready                  - memory finished the current beat
//   addr_select, addr_update   - address register mux select and load strobe
//   mem_read_en, mem_write_en  - memory enables during ACCESS
//   fetch_beat                 - pulse per completed fetch word
//   fetch_ack, data_ack, err   - transaction end pulses (err on timeout)
//   busy                       - high outside IDLE

module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int FETCH_BURST = 2,
  parameter int MAX_WAIT    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       data_we,
  input  logic       mem_ready,
  output logic [1:0] addr_select,
  output logic       addr_update,
  output logic       mem_read_en,
  output logic       mem_write_en,
  output logic       fetch_beat,
  output logic       fetch_ack,
  output logic       data_ack,
  output logic       err,
  output logic       busy
);

  localparam int BEAT_W = (FETCH_BURST > 1) ? $clog2(FETCH_BURST) : 1;

  state_t            state;
  owner_t            owner;
  owner_t            last_grant;
  owner_t            grant;
  logic              we_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic              timer_expired;

  assign grant = pick_owner(fetch_req, data_req, last_grant);

  // Completion is only known combinationally from mem_ready, so this pulse
  // is the one output not registered.
  assign fetch_beat = !rst && (state == ST_ACCESS) && mem_ready && (owner == OWN_FETCH);

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_LOAD),
    .enable  ((state == ST_ACCESS) && !mem_ready),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner        <= OWN_FETCH;
      last_grant   <= OWN_DATA;
      we_q         <= 1'b0;
      beat_cnt     <= '0;
      addr_select  <= SEL_PC;
      addr_update  <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      fetch_ack    <= 1'b0;
      data_ack     <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      addr_update <= 1'b0;
      fetch_ack   <= 1'b0;
      data_ack    <= 1'b0;
      err         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fetch_req || data_req) begin
            owner       <= grant;
            last_grant  <= grant;
            we_q        <= data_we && (grant == OWN_DATA);
            beat_cnt    <= '0;
            addr_update <= 1'b1;
            addr_select <= (grant == OWN_FETCH) ? SEL_PC : SEL_DATA;
            busy        <= 1'b1;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          mem_read_en  <= (owner == OWN_FETCH) || !we_q;
          mem_write_en <= (owner == OWN_DATA) && we_q;
          state        <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            if ((owner == OWN_FETCH) && (beat_cnt != BEAT_W'(FETCH_BURST - 1))) begin
              beat_cnt    <= beat_cnt + BEAT_W'(1);
              addr_update <= 1'b1;
              addr_select <= SEL_INC;
              state       <= ST_LOAD;
            end else begin
              fetch_ack <= (owner == OWN_FETCH);
              data_ack  <= (owner == OWN_DATA);
              state     <= ST_DONE;
            end
          end else if (timer_expired) begin
            // Remaining beats are abandoned; the owner still gets its ack.
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            fetch_ack    <= (owner == OWN_FETCH);
            data_ack     <= (owner == OWN_DATA);
            err          <= 1'b1;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
